// File: rtl/debug_unit_pkg.sv
// Shared constants, types and helpers for the pipeline debug unit.
package debug_unit_pkg;

    localparam int unsigned INSTRUCT_MEM_WIDTH_DEF = 32;

    // Width of a counter that must hold values 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic {
        StIdle,
        StShifting
    } rx_state_e;

endpackage

// File: rtl/rx_buffer.sv
// Parallel-to-serial buffer: loads a status word on start and presents it LSB first, one bit per
// rx_done pulse. Define RX_BUFFER_BIT_COUNT_EN to expose the remaining-bit count on o_bits_left.
module rx_buffer
    import debug_unit_pkg::*;
#(
    parameter int unsigned INSTRUCT_MEM_WIDTH = INSTRUCT_MEM_WIDTH_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_rx_buffer_start,
    input  logic                          i_rx_done,
    input  logic [INSTRUCT_MEM_WIDTH-1:0] i_pipeline_info,
    output logic                          o_rx_buffer_empty,
    output logic                          o_rx_data
`ifdef RX_BUFFER_BIT_COUNT_EN
    ,
    output logic [cnt_width(INSTRUCT_MEM_WIDTH)-1:0] o_bits_left
`endif
);

    localparam int unsigned CntW = cnt_width(INSTRUCT_MEM_WIDTH);

    rx_state_e                   state_q, state_d;
    logic [INSTRUCT_MEM_WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]             cnt_q, cnt_d;

    // State mirrors (cnt != 0); start always wins over a coincident done.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_rx_buffer_start) begin
                    sh_d    = i_pipeline_info;
                    cnt_d   = CntW'(INSTRUCT_MEM_WIDTH);
                    state_d = StShifting;
                end
            end
            StShifting: begin
                if (i_rx_buffer_start) begin
                    sh_d  = i_pipeline_info;
                    cnt_d = CntW'(INSTRUCT_MEM_WIDTH);
                end else if (i_rx_done) begin
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_rx_data         = sh_q[0];
    assign o_rx_buffer_empty = (cnt_q == '0);

`ifdef RX_BUFFER_BIT_COUNT_EN
    assign o_bits_left = cnt_q;
`endif

endmodule

// File: tb/tb_rx_buffer.sv
// Directed bench for rx_buffer: vector table plus hand-written multi-cycle sequences.
module tb_rx_buffer;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          done;
    logic [W-1:0]  pinfo;
    logic          empty;
    logic          data;
`ifdef RX_BUFFER_BIT_COUNT_EN
    logic [5:0]    bits_left;
`endif

    int total = 0;
    int bad   = 0;

    rx_buffer #(
        .INSTRUCT_MEM_WIDTH(W)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_rx_buffer_start(start),
        .i_rx_done        (done),
        .i_pipeline_info  (pinfo),
        .o_rx_buffer_empty(empty),
        .o_rx_data        (data)
`ifdef RX_BUFFER_BIT_COUNT_EN
        ,
        .o_bits_left      (bits_left)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         start;
        logic         done;
        logic [W-1:0] info;
        logic         exp_data;
        logic         exp_empty;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one clock edge's worth of inputs; return 1ns after the edge with pulses cleared.
    task automatic cyc(input logic r, input logic s, input logic d, input logic [W-1:0] info);
        rst   = r;
        start = s;
        done  = d;
        pinfo = info;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        done  = 1'b0;
    endtask

    // Shift out n bits (done pulse then idle cycle), collecting them LSB first.
    task automatic drain(input int n, output logic [W-1:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            word[i] = data;
            cyc(1'b0, 1'b0, 1'b1, pinfo);
            cyc(1'b0, 1'b0, 1'b0, pinfo);
        end
    endtask

    initial begin
        logic [W-1:0] word;
        int           pulses;

        rst   = 1'b0;
        start = 1'b0;
        done  = 1'b0;
        pinfo = '0;

        //            rst   start done  info            data  empty
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,          1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h5,          1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h5,          1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h5,          1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h5,          1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h2,          1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h2,          1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h3,          1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1};

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].rst, vecs[i].start, vecs[i].done, vecs[i].info);
            check($sformatf("vec%0d_data", i), W'(data), W'(vecs[i].exp_data));
            check($sformatf("vec%0d_empty", i), W'(empty), W'(vecs[i].exp_empty));
        end

        // Basic transfer, empty must rise exactly after the 32nd pulse.
        cyc(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            word[i] = data;
            check($sformatf("basic_pre_empty%0d", i), W'(empty), W'(0));
            cyc(1'b0, 1'b0, 1'b1, pinfo);
            if (i == 31) check("basic_empty_after_last", W'(empty), W'(1));
            cyc(1'b0, 1'b0, 1'b0, pinfo);
        end
        check("basic_word", word, 32'hDEAD_BEEF);
        check("basic_data_at_end", W'(data), W'(0));

        // Extra pulses while empty are ignored.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, pinfo);
            check($sformatf("extra%0d_empty", i), W'(empty), W'(1));
            check($sformatf("extra%0d_data", i), W'(data), W'(0));
        end

        // Reload mid-transfer; a later change of i_pipeline_info must not matter.
        cyc(1'b0, 1'b1, 1'b0, 32'h1234_5678);
        drain(5, word);
        check("pre_reload_bits", word, 32'h18);
        cyc(1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5);
        pinfo = 32'h0F0F_0F0F;
        drain(32, word);
        check("reload_word", word, 32'hA5A5_A5A5);
        check("reload_empty", W'(empty), W'(1));

        // Start and done together: start wins, full 32 pulses still needed.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0001);
        check("collide_data", W'(data), W'(1));
`ifdef RX_BUFFER_BIT_COUNT_EN
        check("bits_left_load", W'(bits_left), W'(32));
`endif
        pulses = 0;
        while (!empty && pulses < 40) begin
            cyc(1'b0, 1'b0, 1'b1, pinfo);
            pulses++;
`ifdef RX_BUFFER_BIT_COUNT_EN
            if (pulses == 1) check("bits_left_first", W'(bits_left), W'(31));
`endif
        end
        check("collide_pulses", W'(pulses), W'(32));
`ifdef RX_BUFFER_BIT_COUNT_EN
        check("bits_left_empty", W'(bits_left), W'(0));
`endif

        // Reset after 10 bits.
        cyc(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        drain(10, word);
        check("pre_reset_bits", word, 32'h2EF);
        cyc(1'b1, 1'b0, 1'b0, pinfo);
        check("midreset_empty", W'(empty), W'(1));
        check("midreset_data", W'(data), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
